// File: rtl/argmax_scan_unit.sv
// Handshaked argmax classifier: snapshots one score vector, scans one class per
// cycle and reports winning index, winning score, runner-up score and margin.
module argmax_scan_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter bit SIGNED      = 1'b0,
  parameter bit TIE_LAST    = 1'b1,
  localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_CLASSES*DATA_W-1:0] in_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_index,
  output logic [DATA_W-1:0]             out_max,
  output logic [DATA_W-1:0]             out_second,
  output logic [DATA_W-1:0]             out_margin,
  output logic                          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [DATA_W-1:0] MIN_VAL  = {SIGNED, {(DATA_W-1){1'b0}}};

  state_t state, state_nx;

  logic [DATA_W-1:0] vec_q [NUM_CLASSES];
  logic [DATA_W-1:0] best, second;
  logic [IDX_W-1:0]  best_idx, cnt;

  logic              accept, load_out, win, beats_second;
  logic [DATA_W-1:0] elem, best_nx, second_nx, fin_best, fin_second, margin_nx;
  logic [IDX_W-1:0]  idx_nx, fin_idx;
  logic signed [DATA_W:0] diff;

  // One extra bit lets a single signed compare serve both score encodings.
  function automatic logic signed [DATA_W:0] ext(input logic [DATA_W-1:0] v);
    return SIGNED ? {v[DATA_W-1], v} : {1'b0, v};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    load_out  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept   = 1'b1;
          load_out = (NUM_CLASSES == 1);
          state_nx = (NUM_CLASSES == 1) ? HOLD : SCAN;
        end
      end
      SCAN: begin
        if (cnt == LAST_IDX) begin
          load_out = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    elem         = vec_q[cnt];
    win          = TIE_LAST ? (ext(elem) >= ext(best))   : (ext(elem) > ext(best));
    beats_second = TIE_LAST ? (ext(elem) >= ext(second)) : (ext(elem) > ext(second));
    best_nx      = best;
    second_nx    = second;
    idx_nx       = best_idx;
    if (win) begin
      second_nx = best;
      best_nx   = elem;
      idx_nx    = cnt;
    end else if (beats_second) begin
      second_nx = elem;
    end

    // A single-class vector completes on the acceptance edge itself.
    if (state == IDLE) begin
      fin_best   = in_vec[DATA_W-1:0];
      fin_second = MIN_VAL;
      fin_idx    = '0;
    end else begin
      fin_best   = best_nx;
      fin_second = second_nx;
      fin_idx    = idx_nx;
    end

    diff      = ext(fin_best) - ext(fin_second);
    margin_nx = diff[DATA_W] ? '1 : diff[DATA_W-1:0];
  end

  // NOTE: the snapshot is a plain storage array and carries no reset; nothing
  // reads it before an acceptance has written every entry.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_CLASSES; k++) vec_q[k] <= in_vec[k*DATA_W +: DATA_W];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best       <= '0;
      second     <= '0;
      best_idx   <= '0;
      cnt        <= '0;
      out_index  <= '0;
      out_max    <= '0;
      out_second <= '0;
      out_margin <= '0;
    end else begin
      if (accept) begin
        best     <= in_vec[DATA_W-1:0];
        second   <= MIN_VAL;
        best_idx <= '0;
        cnt      <= IDX_W'(1);
      end else if (state == SCAN) begin
        best     <= best_nx;
        second   <= second_nx;
        best_idx <= idx_nx;
        cnt      <= cnt + 1'b1;
      end
      if (load_out) begin
        out_index  <= fin_idx;
        out_max    <= fin_best;
        out_second <= fin_second;
        out_margin <= margin_nx;
      end
    end
  end

endmodule

// File: tb/tb_argmax_scan_unit.sv
// Randomised bench for argmax_scan_unit: three 10-class variants run in lockstep
// against a value-level reference model, plus a single-class build.
module tb_argmax_scan_unit;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int NI = 3;  // 0: unsigned/tie-last, 1: unsigned/tie-first, 2: signed/tie-last

  logic clk, rst_n;
  logic in_valid, out_ready;
  logic [N*W-1:0] in_vec;

  logic         o_ready [NI];
  logic         o_valid [NI];
  logic [3:0]   o_index [NI];
  logic [W-1:0] o_max   [NI];
  logic [W-1:0] o_sec   [NI];
  logic [W-1:0] o_mg    [NI];
  logic         o_busy  [NI];

  logic         n1_in_valid, n1_out_ready, n1_ready, n1_valid, n1_busy;
  logic [W-1:0] n1_vec, n1_max, n1_sec, n1_mg;
  logic [0:0]   n1_idx;

  int checks = 0;
  int errors = 0;

  int           e_idx [NI];
  logic [W-1:0] e_max [NI], e_sec [NI], e_mg [NI];

  argmax_scan_unit #(.NUM_CLASSES(N), .DATA_W(W), .SIGNED(1'b0), .TIE_LAST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_ready[0]), .in_vec(in_vec),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_index(o_index[0]), .out_max(o_max[0]),
    .out_second(o_sec[0]), .out_margin(o_mg[0]), .busy(o_busy[0]));

  argmax_scan_unit #(.NUM_CLASSES(N), .DATA_W(W), .SIGNED(1'b0), .TIE_LAST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_ready[1]), .in_vec(in_vec),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_index(o_index[1]), .out_max(o_max[1]),
    .out_second(o_sec[1]), .out_margin(o_mg[1]), .busy(o_busy[1]));

  argmax_scan_unit #(.NUM_CLASSES(N), .DATA_W(W), .SIGNED(1'b1), .TIE_LAST(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_ready[2]), .in_vec(in_vec),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_index(o_index[2]), .out_max(o_max[2]),
    .out_second(o_sec[2]), .out_margin(o_mg[2]), .busy(o_busy[2]));

  argmax_scan_unit #(.NUM_CLASSES(1), .DATA_W(W), .SIGNED(1'b0), .TIE_LAST(1'b1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(n1_in_valid), .in_ready(n1_ready), .in_vec(n1_vec),
    .out_valid(n1_valid), .out_ready(n1_out_ready), .out_index(n1_idx), .out_max(n1_max),
    .out_second(n1_sec), .out_margin(n1_mg), .busy(n1_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_signed(input int i);
    return i == 2;
  endfunction

  function automatic bit tie_last(input int i);
    return i != 1;
  endfunction

  function automatic int score(input logic [W-1:0] v, input bit s);
    if (s) return int'($signed(v));
    return int'({16'b0, v});
  endfunction

  // Value-level reference: maximum, its first/last position, and the best of the rest.
  task automatic model(input logic [W-1:0] v [N], input bit s, input bit tl,
                       output int idx, output logic [W-1:0] mx, output logic [W-1:0] sec,
                       output logic [W-1:0] mg);
    int maxv, secv, hits, d;
    maxv = score(v[0], s);
    for (int k = 1; k < N; k++) if (score(v[k], s) > maxv) maxv = score(v[k], s);
    hits = 0;
    idx  = -1;
    for (int k = 0; k < N; k++) begin
      if (score(v[k], s) == maxv) begin
        hits++;
        if (tl || idx < 0) idx = k;
      end
    end
    if (hits > 1) secv = maxv;
    else begin
      secv = s ? -32768 : 0;
      for (int k = 0; k < N; k++)
        if (k != idx && score(v[k], s) > secv) secv = score(v[k], s);
    end
    d = maxv - secv;
    if (d > 65535) d = 65535;
    mx  = v[idx];
    sec = W'(secv);
    mg  = W'(d);
  endtask

  task automatic accept_vec(input logic [W-1:0] v [N]);
    for (int i = 0; i < NI; i++) model(v, is_signed(i), tie_last(i), e_idx[i], e_max[i], e_sec[i], e_mg[i]);
    @(negedge clk);
    for (int k = 0; k < N; k++) in_vec[k*W +: W] = v[k];
    in_valid = 1'b1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_ready[i] !== 1'b1) begin
        errors++; $display("FAIL in_ready_before_accept inst%0d got %b want 1", i, o_ready[i]);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_busy[i] !== 1'b1 || o_valid[i] !== 1'b0) begin
        errors++; $display("FAIL scan_entry inst%0d busy %b valid %b want 1 0", i, o_busy[i], o_valid[i]);
      end
    end
  endtask

  task automatic scan_vec(input logic [W-1:0] v [N], input bit release_after);
    int lat;
    accept_vec(v);
    in_vec = {N{16'hDEAD}};  // snapshot must make this irrelevant
    lat = 0;
    while (o_valid[0] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != N - 1) begin
      errors++; $display("FAIL latency got %0d want %0d", lat, N - 1);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_valid[i] !== 1'b1 || o_index[i] !== 4'(e_idx[i]) || o_max[i] !== e_max[i] ||
          o_sec[i] !== e_sec[i] || o_mg[i] !== e_mg[i] || o_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL result inst%0d got v%b i%0d m%h s%h g%h r%b want v1 i%0d m%h s%h g%h r0",
                 i, o_valid[i], o_index[i], o_max[i], o_sec[i], o_mg[i], o_ready[i],
                 e_idx[i], e_max[i], e_sec[i], e_mg[i]);
      end
    end
    if (release_after) release_result();
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_ready[i] !== 1'b1 || o_busy[i] !== 1'b0 ||
          o_max[i] !== e_max[i] || o_mg[i] !== e_mg[i]) begin
        errors++;
        $display("FAIL release inst%0d got v%b r%b b%b m%h g%h want v0 r1 b0 m%h g%h",
                 i, o_valid[i], o_ready[i], o_busy[i], o_max[i], o_mg[i], e_max[i], e_mg[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic expect_all_zero(input string name);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_valid[i] !== 1'b0 || o_busy[i] !== 1'b0 || o_index[i] !== 4'd0 ||
          o_max[i] !== '0 || o_sec[i] !== '0 || o_mg[i] !== '0) begin
        errors++;
        $display("FAIL %s inst%0d got v%b b%b i%0d m%h s%h g%h want all 0",
                 name, i, o_valid[i], o_busy[i], o_index[i], o_max[i], o_sec[i], o_mg[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_vec = '0;
    #12;
    expect_all_zero("reset");
    checks++;
    if (n1_valid !== 1'b0 || n1_busy !== 1'b0 || n1_max !== '0 || n1_mg !== '0) begin
      errors++; $display("FAIL reset_n1 got v%b b%b m%h g%h want 0", n1_valid, n1_busy, n1_max, n1_mg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (o_ready[i] !== 1'b1) begin
        errors++; $display("FAIL idle_ready inst%0d got %b want 1", i, o_ready[i]);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] v [N];
    for (int k = 0; k < N; k++) v[k] = 16'h0100;
    v[7] = 16'h7F00; v[2] = 16'h4000;
    scan_vec(v, 1'b1);
    for (int k = 0; k < N; k++) v[k] = 16'h0010;
    v[3] = 16'h1234; v[8] = 16'h1234;
    scan_vec(v, 1'b1);
    for (int k = 0; k < N; k++) v[k] = 16'hFF9C;
    v[0] = 16'hFFFB; v[1] = 16'h0003;
    scan_vec(v, 1'b1);
    for (int k = 0; k < N; k++) v[k] = 16'h0000;
    scan_vec(v, 1'b1);
    v[9] = 16'hFFFF; v[0] = 16'h8000;
    scan_vec(v, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] v [N];
    logic [W-1:0] pool [4];
    pool[0] = 16'h0000; pool[1] = 16'h7FFF; pool[2] = 16'h8000; pool[3] = 16'hFFFF;
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < N; k++)
        v[k] = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : W'($urandom);
      scan_vec(v, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] v [N];
    for (int k = 0; k < N; k++) v[k] = W'($urandom);
    scan_vec(v, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_vec   = {N{W'($urandom)}};
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (o_valid[i] !== 1'b1 || o_ready[i] !== 1'b0 || o_index[i] !== 4'(e_idx[i]) ||
            o_max[i] !== e_max[i] || o_sec[i] !== e_sec[i] || o_mg[i] !== e_mg[i]) begin
          errors++;
          $display("FAIL hold_stable cyc%0d inst%0d got v%b r%b i%0d m%h s%h g%h want v1 r0 i%0d m%h s%h g%h",
                   c, i, o_valid[i], o_ready[i], o_index[i], o_max[i], o_sec[i], o_mg[i],
                   e_idx[i], e_max[i], e_sec[i], e_mg[i]);
        end
      end
    end
    in_valid = 1'b0;
    release_result();
    for (int k = 0; k < N; k++) v[k] = W'($urandom);
    scan_vec(v, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    logic [W-1:0] v [N];
    for (int k = 0; k < N; k++) v[k] = W'($urandom) | 16'h0001;
    accept_vec(v);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all_zero("reset_mid_scan");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) v[k] = W'($urandom);
    scan_vec(v, 1'b1);
  endtask

  task automatic test_single_class();
    logic [W-1:0] val;
    for (int t = 0; t < 4; t++) begin
      val = (t == 0) ? 16'h0005 : W'($urandom);
      @(negedge clk);
      n1_vec = val;
      n1_in_valid = 1'b1;
      @(posedge clk); #1;
      n1_in_valid = 1'b0;
      checks++;
      if (n1_valid !== 1'b1 || n1_idx !== 1'b0 || n1_max !== val || n1_sec !== '0 ||
          n1_mg !== val || n1_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_class got v%b i%0d m%h s%h g%h r%b want v1 i0 m%h s0000 g%h r0",
                 n1_valid, n1_idx, n1_max, n1_sec, n1_mg, n1_ready, val, val);
      end
      @(negedge clk);
      n1_out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (n1_valid !== 1'b0 || n1_ready !== 1'b1) begin
        errors++; $display("FAIL single_release got v%b r%b want v0 r1", n1_valid, n1_ready);
      end
      @(negedge clk);
      n1_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_scan();
    test_single_class();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
